crc16_frame_tx: RTL and testbench
=================================

CRC16_FRAME_TX -- requirements
Module: crc16_frame_tx

Interface
REQ-001 Parameter: G_XOR_OUT, default 0, 1 = appended CRC is final CRC XOR 0xFFFF.
REQ-002 Parameter: G_CNT_W, default 16, width of frame counter.
REQ-003 i_Clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_Rst  in  1  synchronous, active-high reset.
REQ-005 i_DV  in  1  upstream payload byte valid.
REQ-006 i_Data  in  8  upstream payload byte.
REQ-007 i_Last  in  1  qualifies i_DV byte as final payload byte of frame.
REQ-008 o_Ready  out  1  block accepts i_Data this cycle (transfer = i_DV & o_Ready).
REQ-009 o_DV  out  1  output byte valid.
REQ-010 o_Data  out  8  output byte (payload, then CRC high, then CRC low).
REQ-011 o_Last  out  1  asserted with CRC low byte only.
REQ-012 i_Ready  in  1  downstream accepts o_Data (transfer = o_DV & i_Ready).
REQ-013 o_Frame_Count  out  G_CNT_W  count of frames fully emitted (CRC low byte transferred).

Function
REQ-014 CRC SHALL be CRC-16-CCITT, poly 0x1021, init 0xFFFF, non-reflected, MSB-first per byte, byte-parallel update.
REQ-015 CRC SHALL be re-initialised to 0xFFFF when a frame's CRC low byte is transferred and on reset, so every frame starts at 0xFFFF.
REQ-016 FSM states: S_PAYLOAD, S_CRC_HI, S_CRC_LO; reset state S_PAYLOAD.
REQ-017 S_PAYLOAD: o_Ready = ~o_DV | i_Ready; each accepted byte updates CRC and loads output register next cycle (latency 1) with o_Last = 0.
REQ-018 Accepted byte with i_Last = 1 SHALL move FSM to S_CRC_HI after its payload byte is loaded.
REQ-019 S_CRC_HI: o_Ready = 0; when output register free (~o_DV | i_Ready), load CRC[15:8] (XOR 0xFF if G_XOR_OUT) and go to S_CRC_LO.
REQ-020 S_CRC_LO: o_Ready = 0; when output register free, load CRC[7:0] (XOR 0xFF if G_XOR_OUT) with o_Last = 1 and go to S_PAYLOAD.
REQ-021 o_Data/o_Last SHALL hold stable while o_DV = 1 and i_Ready = 0; no byte dropped or duplicated under any backpressure.
REQ-022 Back-to-back frames: first byte of next frame SHALL be accepted in the same cycle the CRC low byte is transferred; sustained throughput 1 byte/cycle within payload, 2 CRC bubble cycles at upstream per frame.
REQ-023 Single-byte frame (i_DV & i_Last on first byte) SHALL be valid: output payload, CRC hi, CRC lo.
REQ-024 i_DV while o_Ready = 0 SHALL be ignored (upstream holds); i_Last without i_DV ignored.
REQ-025 o_Frame_Count SHALL increment on CRC low byte transfer and wrap from all-ones to 0.

Reset
REQ-026 Reset SHALL force: state S_PAYLOAD, CRC 0xFFFF, o_DV 0, o_Data 0x00, o_Last 0, o_Frame_Count 0; o_Ready 1 in first cycle after reset.
REQ-027 Reset mid-frame (any state) SHALL abandon the frame: no CRC bytes emitted, counter not incremented.

Structure
REQ-028 Shared package crc16_pkg SHALL hold: CRC16_POLY 0x1021, CRC16_INIT 0xFFFF, state enumeration, and the byte-update function.
REQ-029 One sub-module crc16_ccitt_step: combinational next-CRC from (crc[15:0], data[7:0]); the FSM/output register lives in crc16_frame_tx.

Verification
REQ-030 Frame "123456789" (0x31..0x39, i_Last on 0x39), i_Ready = 1 -> o_Data 0x31..0x39, 0x29, 0xB1 (o_Last), o_Frame_Count 1.
REQ-031 Same frame, G_XOR_OUT = 1 -> CRC bytes 0xD6, 0x4E.
REQ-032 Single byte 0x00 frame -> 0x00, 0xE1, 0xF0; then immediately "123456789" back-to-back -> 0x29, 0xB1 (proves CRC re-init), count 2.
REQ-033 Random i_Ready toggling (~50%) over 100 frames of random length 1-64 -> output stream equals reference model byte-for-byte, no holds violated.
REQ-034 Reset asserted while in S_CRC_HI with i_Ready = 0 -> o_DV 0 next cycle, count unchanged, following "123456789" frame yields 0x29, 0xB1.
REQ-035 G_CNT_W = 2, 5 frames -> o_Frame_Count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/crc16_pkg.sv
// Shared CRC-16-CCITT constants, frame FSM state encoding and the byte-parallel update function.
// The update function is purely combinational and is used by the step module.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    S_PAYLOAD = 2'd0,
    S_CRC_HI  = 2'd1,
    S_CRC_LO  = 2'd2
  } state_t;

  // Non-reflected, MSB-first: eight serial steps unrolled into one byte update.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) begin
        c = c ^ CRC16_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt_step.sv
// Combinational next-CRC for one payload byte; zero latency, no flow control.
module crc16_ccitt_step
  import crc16_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  assign crc_out = crc16_byte(crc_in, data);

endmodule

// File: rtl/crc16_frame_tx.sv
// Appends a CRC-16-CCITT (high byte, then low byte) to each payload frame; one output register, latency 1.
// Upstream stalls while the output register is full or the two CRC bytes are being emitted.
module crc16_frame_tx
  import crc16_pkg::*;
#(
  parameter bit G_XOR_OUT = 1'b0,
  parameter int G_CNT_W   = 16
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_DV,
  input  logic [7:0]         i_Data,
  input  logic               i_Last,
  output logic               o_Ready,
  output logic               o_DV,
  output logic [7:0]         o_Data,
  output logic               o_Last,
  input  logic               i_Ready,
  output logic [G_CNT_W-1:0] o_Frame_Count
);

  localparam logic [7:0] XOR_MASK = G_XOR_OUT ? 8'hFF : 8'h00;

  state_t               state, state_nxt;
  logic [15:0]          crc, crc_nxt, crc_base, crc_upd;
  logic                 dv_nxt, last_nxt;
  logic [7:0]           data_nxt;
  logic [G_CNT_W-1:0]   cnt_nxt;
  logic                 out_free, lo_xfer;

  assign out_free = ~o_DV | i_Ready;
  assign lo_xfer  = o_DV & i_Ready & o_Last;

  // A byte accepted in the same cycle the previous CRC low byte leaves must start from the init value.
  assign crc_base = lo_xfer ? CRC16_INIT : crc;

  crc16_ccitt_step u_step (
    .crc_in  (crc_base),
    .data    (i_Data),
    .crc_out (crc_upd)
  );

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    dv_nxt    = o_DV;
    data_nxt  = o_Data;
    last_nxt  = o_Last;
    cnt_nxt   = o_Frame_Count;
    o_Ready   = 1'b0;

    if (o_DV && i_Ready) begin
      dv_nxt   = 1'b0;
      last_nxt = 1'b0;
    end
    if (lo_xfer) begin
      cnt_nxt = o_Frame_Count + G_CNT_W'(1);
      crc_nxt = CRC16_INIT;
    end

    case (state)
      S_PAYLOAD: begin
        o_Ready = out_free;
        if (i_DV && out_free) begin
          crc_nxt  = crc_upd;
          dv_nxt   = 1'b1;
          data_nxt = i_Data;
          last_nxt = 1'b0;
          if (i_Last) begin
            state_nxt = S_CRC_HI;
          end
        end
      end
      S_CRC_HI: begin
        if (out_free) begin
          dv_nxt    = 1'b1;
          data_nxt  = crc[15:8] ^ XOR_MASK;
          last_nxt  = 1'b0;
          state_nxt = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (out_free) begin
          dv_nxt    = 1'b1;
          data_nxt  = crc[7:0] ^ XOR_MASK;
          last_nxt  = 1'b1;
          state_nxt = S_PAYLOAD;
        end
      end
      default: begin
        state_nxt = S_PAYLOAD;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= S_PAYLOAD;
      crc           <= CRC16_INIT;
      o_DV          <= 1'b0;
      o_Data        <= 8'h00;
      o_Last        <= 1'b0;
      o_Frame_Count <= '0;
    end else begin
      state         <= state_nxt;
      crc           <= crc_nxt;
      o_DV          <= dv_nxt;
      o_Data        <= data_nxt;
      o_Last        <= last_nxt;
      o_Frame_Count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Directed and randomised-backpressure bench; three instances share stimulus (default, XOR-out, 2-bit counter).
module tb_crc16_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_dv, i_last, i_rdy;
  logic [7:0]  i_data;

  logic        o_ready, o_dv, o_last;
  logic [7:0]  o_data;
  logic [15:0] o_cnt;
  logic        x_ready, x_dv, x_last;
  logic [7:0]  x_data;
  logic [15:0] x_cnt;
  logic        c_ready, c_dv, c_last;
  logic [7:0]  c_data;
  logic [1:0]  c_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hold_viol = 0;
  logic [8:0]  out_q[$];
  logic [7:0]  xq[$];
  int          acc_q[$];
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_out;

  always #5 clk = ~clk;

  crc16_frame_tx dut (
    .i_Clk(clk), .i_Rst(rst), .i_DV(i_dv), .i_Data(i_data), .i_Last(i_last),
    .o_Ready(o_ready), .o_DV(o_dv), .o_Data(o_data), .o_Last(o_last),
    .i_Ready(i_rdy), .o_Frame_Count(o_cnt)
  );

  crc16_frame_tx #(.G_XOR_OUT(1'b1)) dut_x (
    .i_Clk(clk), .i_Rst(rst), .i_DV(i_dv), .i_Data(i_data), .i_Last(i_last),
    .o_Ready(x_ready), .o_DV(x_dv), .o_Data(x_data), .o_Last(x_last),
    .i_Ready(i_rdy), .o_Frame_Count(x_cnt)
  );

  crc16_frame_tx #(.G_CNT_W(2)) dut_c (
    .i_Clk(clk), .i_Rst(rst), .i_DV(i_dv), .i_Data(i_data), .i_Last(i_last),
    .o_Ready(c_ready), .o_DV(c_dv), .o_Data(c_data), .o_Last(c_last),
    .i_Ready(i_rdy), .o_Frame_Count(c_cnt)
  );

  always @(posedge clk) cyc++;

  // Inputs only change just after the rising edge, so the falling edge sees what the next edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_dv && i_rdy) begin
        out_q.push_back({o_last, o_data});
        xq.push_back(x_data);
      end
      if (i_dv && o_ready) acc_q.push_back(cyc);
      if (prev_stall && !(o_dv && {o_last, o_data} == prev_out)) hold_viol++;
    end
    prev_stall = !rst && o_dv && !i_rdy;
    prev_out   = {o_last, o_data};
  end

  function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; i_dv = 1'b0; i_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_q.delete(); xq.delete(); acc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    i_dv = 1'b1; i_data = d; i_last = last;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL send_byte timeout: o_Ready stayed 0, need 1 (byte %h)", d);
    end
    @(posedge clk); #1;
    i_dv = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (out_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (out_q.size() < n) begin
      n_err++;
      $display("FAIL wait_out: got %0d bytes, need %0d", out_q.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp += 6;
    if (o_dv !== 1'b0)     begin n_err++; $display("FAIL reset_dv: got %b need 0", o_dv); end
    if (o_data !== 8'h00)  begin n_err++; $display("FAIL reset_data: got %h need 00", o_data); end
    if (o_last !== 1'b0)   begin n_err++; $display("FAIL reset_last: got %b need 0", o_last); end
    if (o_cnt !== 16'd0)   begin n_err++; $display("FAIL reset_cnt: got %0d need 0", o_cnt); end
    if (c_cnt !== 2'd0)    begin n_err++; $display("FAIL reset_cnt_w2: got %0d need 0", c_cnt); end
    if (o_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %b need 1", o_ready); end
  endtask

  task automatic test_check_value();
    logic [7:0] exp [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    apply_reset();
    i_rdy = 1'b1;
    send_byte(8'h31, 1'b0);
    n_cmp++;
    if (o_dv !== 1'b1 || o_data !== 8'h31) begin
      n_err++; $display("FAIL latency1: got dv=%b data=%h need dv=1 data=31", o_dv, o_data);
    end
    for (int i = 1; i < 9; i++) send_byte(exp[i], i == 8);
    wait_out(11);
    for (int i = 0; i < 11 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== {i == 10, exp[i]}) begin
        n_err++; $display("FAIL check_value[%0d]: got last=%b data=%h need last=%b data=%h",
                          i, out_q[i][8], out_q[i][7:0], i == 10, exp[i]);
      end
    end
    n_cmp++;
    if (o_cnt !== 16'd1) begin n_err++; $display("FAIL check_value_cnt: got %0d need 1", o_cnt); end
  endtask

  task automatic test_xor_out();
    n_cmp += 3;
    if (xq.size() < 11) begin
      n_err += 3; $display("FAIL xor_out: got %0d bytes need 11", xq.size());
    end else begin
      if (xq[0] !== 8'h31)  begin n_err++; $display("FAIL xor_payload: got %h need 31", xq[0]); end
      if (xq[9] !== 8'hD6)  begin n_err++; $display("FAIL xor_crc_hi: got %h need D6", xq[9]); end
      if (xq[10] !== 8'h4E) begin n_err++; $display("FAIL xor_crc_lo: got %h need 4E", xq[10]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [14] = '{8'h00, 8'hE1, 8'hF0, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                             8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    apply_reset();
    i_rdy = 1'b1;
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8);
    wait_out(14);
    for (int i = 0; i < 14 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== {(i == 2) || (i == 13), exp[i]}) begin
        n_err++; $display("FAIL b2b[%0d]: got last=%b data=%h need data=%h",
                          i, out_q[i][8], out_q[i][7:0], exp[i]);
      end
    end
    n_cmp += 3;
    if (acc_q.size() < 3) begin
      n_err += 2; $display("FAIL b2b_accepts: got %0d need >=3", acc_q.size());
    end else begin
      if (acc_q[1] - acc_q[0] !== 3) begin n_err++; $display("FAIL b2b_gap: got %0d cycles need 3", acc_q[1] - acc_q[0]); end
      if (acc_q[2] - acc_q[1] !== 1) begin n_err++; $display("FAIL b2b_rate: got %0d cycles need 1", acc_q[2] - acc_q[1]); end
    end
    if (o_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_cnt: got %0d need 2", o_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    i_rdy = 1'b0;
    send_byte(8'h41, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp += 3;
    if (o_dv !== 1'b0)      begin n_err++; $display("FAIL midrst_dv: got %b need 0", o_dv); end
    if (o_cnt !== 16'd0)    begin n_err++; $display("FAIL midrst_cnt: got %0d need 0", o_cnt); end
    if (out_q.size() !== 0) begin n_err++; $display("FAIL midrst_emitted: got %0d bytes need 0", out_q.size()); end
    i_rdy = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8);
    wait_out(11);
    n_cmp += 3;
    if (out_q.size() < 11) begin
      n_err += 2; $display("FAIL midrst_frame: got %0d bytes need 11", out_q.size());
    end else begin
      if (out_q[9] !== 9'h029)  begin n_err++; $display("FAIL midrst_crc_hi: got %h need 029", out_q[9]); end
      if (out_q[10] !== 9'h1B1) begin n_err++; $display("FAIL midrst_crc_lo: got %h need 1B1", out_q[10]); end
    end
    if (o_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_cnt_after: got %0d need 1", o_cnt); end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    i_rdy = 1'b1;
    for (int f = 0; f < 5; f++) begin
      send_byte(8'(f), 1'b1);
      wait_out(3 * (f + 1));
      n_cmp++;
      if (c_cnt !== exp[f]) begin n_err++; $display("FAIL cnt_wrap[%0d]: got %0d need %0d", f, c_cnt, exp[f]); end
    end
    n_cmp++;
    if (o_cnt !== 16'd5) begin n_err++; $display("FAIL cnt_wide: got %0d need 5", o_cnt); end
  endtask

  task automatic test_random_backpressure();
    logic [8:0]  in_q[$];
    logic [8:0]  exp_q[$];
    logic [15:0] c;
    logic [7:0]  d;
    int          len;
    bit          sent = 1'b0;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 64);
      c = 16'hFFFF;
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom_range(0, 255));
        c = ref_crc(c, d);
        in_q.push_back({i == len - 1, d});
        exp_q.push_back({1'b0, d});
      end
      exp_q.push_back({1'b0, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
    apply_reset();
    hold_viol = 0;
    fork
      begin
        foreach (in_q[i]) send_byte(in_q[i][7:0], in_q[i][8]);
        sent = 1'b1;
      end
      begin
        while (!sent) begin
          @(posedge clk); #1;
          i_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    i_rdy = 1'b1;
    wait_out(exp_q.size());
    n_cmp++;
    if (out_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL rand_len: got %0d bytes need %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL rand_stream[%0d]: got %h need %h", i, out_q[i], exp_q[i]);
        break;
      end
    end
    n_cmp += 2;
    if (hold_viol !== 0)   begin n_err++; $display("FAIL rand_hold: got %0d violations need 0", hold_viol); end
    if (o_cnt !== 16'd100) begin n_err++; $display("FAIL rand_cnt: got %0d need 100", o_cnt); end
  endtask

  initial begin
    rst = 1'b1; i_dv = 1'b0; i_last = 1'b0; i_data = 8'h00; i_rdy = 1'b1;
    test_reset();
    test_check_value();
    test_xor_out();
    test_back_to_back();
    test_reset_mid_frame();
    test_cnt_wrap();
    test_random_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
